blockram_arbiter: RTL and testbench

//  Shares the single read-only blockram (17-bit word address, 32-bit data) between two

---
 rtl/blockram_pkg.sv | 22 ++
 rtl/blockram_rsp_pipe.sv | 26 ++
 rtl/blockram_arbiter.sv | 88 ++++++++
 tb/tb_blockram_arbiter.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/blockram_pkg.sv
// Shared types and constants for the blockram arbiter slice.
// Optional feature macro: BRAM_HOLE_ERR_EN (flags reads of the unmapped address hole).
package blockram_pkg;

    localparam int NUM_PORTS = 2;
    localparam logic [16:0] BRAM_HOLE_LO = 17'h13000;
    localparam logic [16:0] BRAM_HOLE_HI = 17'h18FFF;

    typedef logic port_id_t;

    typedef struct packed {
        logic     valid;
        port_id_t port;
        logic     hole;
    } rsp_tag_t;

    // True when a word address falls inside the unmapped hole.
    function automatic logic is_hole(input logic [16:0] addr);
        return (addr >= BRAM_HOLE_LO) && (addr <= BRAM_HOLE_HI);
    endfunction

endpackage

// File: rtl/blockram_rsp_pipe.sv
// Fixed-depth shift register carrying response tags alongside the RAM read latency.
module blockram_rsp_pipe
    import blockram_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic     clk,
    input  logic     rst,
    input  rsp_tag_t tag_in,
    output rsp_tag_t tag_out
);

    rsp_tag_t [DEPTH-1:0] tag_pipe;

    // Shift one tag per cycle; reset flushes every stage to invalid.
    always_ff @(posedge clk) begin
        if (rst) begin
            tag_pipe <= '0;
        end else begin
            tag_pipe <= {tag_pipe[DEPTH-2:0], tag_in};
        end
    end

    assign tag_out = tag_pipe[DEPTH-1];

endmodule

// File: rtl/blockram_arbiter.sv
// Round-robin read arbiter sharing one blockram between fetch (port 0) and data/DMA (port 1).
// Optional feature macro: BRAM_HOLE_ERR_EN -- hole reads return rsp_err=1 and zero data.
module blockram_arbiter
    import blockram_pkg::*;
#(
    parameter int READ_LAT = 1,
    parameter int AW       = 17,
    parameter int DW       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_PORTS-1:0]          req_valid,
    input  logic [NUM_PORTS-1:0][AW-1:0]  req_addr,
    output logic [NUM_PORTS-1:0]          req_ready,
    output logic [NUM_PORTS-1:0]          rsp_valid,
    output logic [DW-1:0]                 rsp_data,
    output logic                          rsp_err,
    output logic [AW-1:0]                 ram_addr,
    input  logic [DW-1:0]                 ram_data
);

    port_id_t             rr_last;
    port_id_t             win;
    logic [NUM_PORTS-1:0] grant;
    logic                 any_grant;
    rsp_tag_t             tag_in;
    rsp_tag_t             tag_out;

    // Pick the winner: a lone requester wins, contention goes to the port not served last.
    always_comb begin
        grant = '0;
        win   = 1'b0;
        if (!rst) begin
            case (req_valid)
                2'b01:   begin grant = 2'b01; win = 1'b0; end
                2'b10:   begin grant = 2'b10; win = 1'b1; end
                2'b11:   begin win = ~rr_last; grant = win ? 2'b10 : 2'b01; end
                default: begin grant = '0; win = 1'b0; end
            endcase
        end
    end

    assign req_ready = grant;
    assign any_grant = |grant;

    // Register the granted address and remember who was served; both hold when idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            ram_addr <= '0;
            rr_last  <= 1'b1;
        end else if (any_grant) begin
            ram_addr <= req_addr[win];
            rr_last  <= win;
        end
    end

    // Build the tag that follows the read down the latency pipe (bubble when idle).
    always_comb begin
        tag_in       = '0;
        tag_in.valid = any_grant;
        tag_in.port  = win;
`ifdef BRAM_HOLE_ERR_EN
        tag_in.hole  = any_grant && is_hole(17'(req_addr[win]));
`else
        tag_in.hole  = 1'b0;
`endif
    end

    // One stage for the address register plus READ_LAT stages for the RAM itself.
    blockram_rsp_pipe #(.DEPTH(READ_LAT + 1)) u_rsp_pipe (
        .clk     (clk),
        .rst     (rst),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    assign rsp_valid[0] = tag_out.valid && (tag_out.port == 1'b0);
    assign rsp_valid[1] = tag_out.valid && (tag_out.port == 1'b1);

`ifdef BRAM_HOLE_ERR_EN
    assign rsp_err  = tag_out.valid && tag_out.hole;
    assign rsp_data = tag_out.hole ? '0 : ram_data;
`else
    assign rsp_err  = 1'b0;
    assign rsp_data = ram_data;
`endif

endmodule

// File: tb/tb_blockram_arbiter.sv
// Scoreboard bench for blockram_arbiter: stimulus pushes expected responses on accept,
// an independent monitor pops and compares whenever a response strobe appears.
module tb_blockram_arbiter;

    localparam int LAT = 2;
    localparam int AW  = 17;
    localparam int DW  = 32;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            req_valid;
    logic [1:0][AW-1:0]    req_addr;
    logic [1:0]            req_ready;
    logic [1:0]            rsp_valid;
    logic [DW-1:0]         rsp_data;
    logic                  rsp_err;
    logic [AW-1:0]         ram_addr;
    logic [DW-1:0]         ram_data;

    typedef struct {
        logic        port;
        logic [31:0] data;
        logic        err;
        int          cyc;
        logic [16:0] addr;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   passed = 0;
    int   cyc    = 0;
    bit   in_reset_window = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    blockram_arbiter #(.READ_LAT(LAT), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_addr  (req_addr),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .ram_addr  (ram_addr),
        .ram_data  (ram_data)
    );

    function automatic logic hole(input logic [16:0] a);
        return (a >= 17'h13000) && (a <= 17'h18FFF);
    endfunction

    // ROM contents: holes read as zero, everything else an address-derived pattern.
    function automatic logic [31:0] rom(input logic [16:0] a);
        if (hole(a)) return 32'h0;
        return {a[14:0], a} ^ 32'hA5C3_0F1E;
    endfunction

    // Blockram model: address sampled on the edge, data LAT cycles later.
    logic [31:0] ram_q [LAT];
    always @(posedge clk) begin
        ram_q[0] <= rom(ram_addr);
        for (int i = 1; i < LAT; i++) ram_q[i] <= ram_q[i-1];
    end
    assign ram_data = ram_q[LAT-1];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act === req) passed++;
        else $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, req, cyc);
    endtask

    // Monitor: compare every response against the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst) begin
            check("ready_without_valid", 64'(req_ready & ~req_valid), 64'd0);
            if (rsp_valid != 2'b00) begin
                if (rsp_valid == 2'b11) begin
                    check("rsp_onehot", 64'(rsp_valid), 64'd1);
                end else if (exp_q.size() == 0) begin
                    check("rsp_unexpected", 64'(rsp_valid), 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("rsp_port", 64'(rsp_valid[1]), 64'(e.port));
                    check("rsp_data", 64'(rsp_data), 64'(e.data));
                    check("rsp_err", 64'(rsp_err), 64'(e.err));
                    check("rsp_latency", 64'(cyc), 64'(e.cyc));
                end
            end
        end
    end

    // Drive one cycle of requests; optionally check the grant; push accepted reads.
    task automatic step(input logic [1:0] v, input logic [16:0] a0, input logic [16:0] a1,
                        input logic [1:0] exp_rdy, input bit chk, output logic [1:0] rdy);
        exp_t e;
        req_valid   = v;
        req_addr[0] = a0;
        req_addr[1] = a1;
        @(negedge clk);
        rdy = req_ready;
        if (chk) check("grant", 64'(req_ready), 64'(exp_rdy));
        for (int p = 0; p < 2; p++) begin
            if (req_valid[p] && req_ready[p] && !rst) begin
                e.port = p[0];
                e.addr = req_addr[p];
                e.data = rom(req_addr[p]);
`ifdef BRAM_HOLE_ERR_EN
                e.err  = hole(req_addr[p]);
`else
                e.err  = 1'b0;
`endif
                e.cyc  = cyc + LAT + 1;
                exp_q.push_back(e);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        exp_q.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        req_valid = '0;
        while (exp_q.size() != 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("drain_timeout", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin : stim
        logic [1:0]  r;
        logic [1:0]  pv;
        logic [16:0] pa [2];

        rst = 1'b1;
        req_valid = '0;
        req_addr = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_ready", 64'(req_ready), 64'd0);
        check("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check("reset_rsp_err", 64'(rsp_err), 64'd0);
        check("reset_ram_addr", 64'(ram_addr), 64'd0);
        rst = 1'b0;

        // Single port 0 read.
        step(2'b01, 17'h00010, 17'h0, 2'b01, 1'b1, r);
        drain();

        // Contention for 6 cycles: strict alternation starting with port 0.
        do_reset();
        for (int i = 0; i < 6; i++)
            step(2'b11, 17'h00100 + 17'(i), 17'h1F000 + 17'(i),
                 (i % 2 == 0) ? 2'b01 : 2'b10, 1'b1, r);
        drain();

        // Port 1 alone for 4 cycles, then port 0 joins and wins.
        do_reset();
        for (int i = 0; i < 4; i++)
            step(2'b10, 17'h0, 17'h00400 + 17'(i), 2'b10, 1'b1, r);
        step(2'b11, 17'h00500, 17'h00404, 2'b01, 1'b1, r);
        step(2'b11, 17'h00501, 17'h00404, 2'b10, 1'b1, r);
        drain();

        // Reset with two reads in flight: no responses afterwards, port 0 first.
        step(2'b01, 17'h00600, 17'h0, 2'b01, 1'b1, r);
        step(2'b10, 17'h0, 17'h00601, 2'b10, 1'b1, r);
        rst = 1'b1;
        req_valid = '0;
        @(posedge clk);
        #1;
        exp_q.delete();
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            check("no_rsp_after_reset", 64'(rsp_valid), 64'd0);
            @(posedge clk);
            #1;
        end
        step(2'b11, 17'h00700, 17'h00701, 2'b01, 1'b1, r);
        drain();

        // Hole boundaries and outside addresses.
        step(2'b01, 17'h15000, 17'h0, 2'b01, 1'b1, r);
        step(2'b10, 17'h0, 17'h19000, 2'b10, 1'b1, r);
        step(2'b01, 17'h13000, 17'h0, 2'b01, 1'b1, r);
        step(2'b10, 17'h0, 17'h18FFF, 2'b10, 1'b1, r);
        step(2'b01, 17'h12FFF, 17'h0, 2'b01, 1'b1, r);
        drain();

        // Random traffic; a refused request keeps its address until accepted.
        pv = '0;
        pa[0] = '0;
        pa[1] = '0;
        for (int c = 0; c < 10000; c++) begin
            for (int p = 0; p < 2; p++) begin
                if (!pv[p]) begin
                    pv[p] = ($urandom_range(0, 9) < 6);
                    pa[p] = 17'($urandom);
                end
            end
            step(pv, pa[0], pa[1], 2'b00, 1'b0, r);
            pv = pv & ~r;
        end
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
